// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_pkg
//  Description : Shared configuration and row type for the DA GEMM datapath,
//                its operand sequencer and the result collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package gemm_pkg;

    localparam int DATA_WIDTH_A      = 8;   // operand width = bit-serial cycles per row
    localparam int DATA_WIDTH_output = 8;   // width of each result element
    localparam int M                 = 2;   // rows per tile
    localparam int N                 = 4;   // columns per row

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH_A);
    localparam int ROW_CNT_W = (M > 1) ? $clog2(M) : 1;

    typedef logic signed [DATA_WIDTH_output-1:0] elem_t;
    typedef elem_t row_t [N];

endpackage
`default_nettype wire

// File: rtl/gemm_tile_buf.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_tile_buf
//  Description : Two-bank x M-row ping-pong tile store, one synchronous write
//                port and one combinational read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module gemm_tile_buf
    import gemm_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic                 wr_bank,
    input  logic [ROW_CNT_W-1:0] wr_row,
    input  row_t                 wr_data,
    input  logic                 rd_bank,
    input  logic [ROW_CNT_W-1:0] rd_row,
    output row_t                 rd_data
);

    row_t r_mem [2][M];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_bank][wr_row] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_bank][rd_row];

endmodule
`default_nettype wire

// File: rtl/gemm_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_result_collector
//  Description : Samples GEMM row results once per completed row, assembles
//                M x N tiles in a ping-pong buffer and drains them with
//                valid/ready. Optional macro GEMM_COLLECT_RELU_EN clamps
//                negative elements to zero at capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module gemm_result_collector
    import gemm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic gen_done,
    input  row_t final_out,
    output logic stall,
    output logic out_valid,
    input  logic out_ready,
    output row_t out_data,
    output logic out_last,
    output logic overflow_err
);

    localparam logic [BIT_CNT_W-1:0] C_BIT_LAST = BIT_CNT_W'(DATA_WIDTH_A - 1);
    localparam logic [ROW_CNT_W-1:0] C_ROW_LAST = ROW_CNT_W'(M - 1);

    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [ROW_CNT_W-1:0] r_row_cnt;
    logic [ROW_CNT_W-1:0] r_cap_row;
    logic [ROW_CNT_W-1:0] r_rd_row;
    logic                 r_primed;
    logic                 r_wr_bank;
    logic                 r_rd_bank;
    logic [1:0]           r_full;
    logic                 r_stall;
    logic                 r_overflow;

    logic       w_capture;
    logic       w_write;
    logic       w_fill_done;
    logic       w_accept;
    logic       w_drain_done;
    logic       w_wr_bank_nxt;
    logic [1:0] w_full_nxt;
    row_t       w_wr_data;
    row_t       w_rd_data;

    // The GEMM's row result is valid on the first bit cycle of the next row.
    assign w_capture    = gen_done && (r_bit_cnt == '0) && r_primed;
    assign w_write      = w_capture && !r_full[r_wr_bank];
    assign w_fill_done  = w_write && (r_cap_row == C_ROW_LAST);

    assign out_valid    = r_full[r_rd_bank];
    assign out_last     = out_valid && (r_rd_row == C_ROW_LAST);
    assign w_accept     = out_valid && out_ready;
    assign w_drain_done = w_accept && out_last;

    assign w_wr_bank_nxt = r_wr_bank ^ w_fill_done;
    assign stall         = r_stall;
    assign overflow_err  = r_overflow;

    // Fill and drain always target different banks, so both may land together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_drain_done) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_fill_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
`ifdef GEMM_COLLECT_RELU_EN
            w_wr_data[i] = final_out[i][DATA_WIDTH_output-1] ? '0 : final_out[i];
`else
            w_wr_data[i] = final_out[i];
`endif
            out_data[i] = out_valid ? w_rd_data[i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_row_cnt  <= '0;
            r_cap_row  <= '0;
            r_primed   <= 1'b0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_rd_row   <= '0;
            r_full     <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (gen_done) begin
                if (r_bit_cnt == C_BIT_LAST) begin
                    r_bit_cnt <= '0;
                    r_primed  <= 1'b1;
                    r_cap_row <= r_row_cnt;
                    r_row_cnt <= (r_row_cnt == C_ROW_LAST) ? '0 : r_row_cnt + ROW_CNT_W'(1);
                end else begin
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                end
            end
            if (w_capture && r_full[r_wr_bank]) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                r_rd_row <= out_last ? '0 : r_rd_row + ROW_CNT_W'(1);
            end
            if (w_drain_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
            r_full    <= w_full_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            // Write bank still full after the update means both banks are full.
            r_stall   <= w_full_nxt[w_wr_bank_nxt];
        end
    end

    gemm_tile_buf u_tile_buf (
        .clk     (clk),
        .we      (w_write),
        .wr_bank (r_wr_bank),
        .wr_row  (r_cap_row),
        .wr_data (w_wr_data),
        .rd_bank (r_rd_bank),
        .rd_row  (r_rd_row),
        .rd_data (w_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_gemm_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gemm_result_collector
//  Description : Scoreboard bench for gemm_result_collector with a tile-level
//                reference model and directed plus random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm_result_collector;
    import gemm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gen_done = 1'b0;
    logic out_ready = 1'b0;
    row_t final_out;
    row_t out_data;
    logic stall;
    logic out_valid;
    logic out_last;
    logic overflow_err;

    gemm_result_collector dut (
        .clk          (clk),
        .rst          (rst),
        .gen_done     (gen_done),
        .final_out    (final_out),
        .stall        (stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    bit          active   = 1'b0;

    // Reference model state: tile-level view of the collector.
    logic [63:0] exp_data_q [$];
    bit          exp_last_q [$];
    logic [63:0] partial_rows [M];
    int          gcount     = 0;
    int          tiles_full = 0;
    bit          exp_ovf    = 1'b0;
    bit          drain_flag = 1'b0;
    int          row_idx;
    int          t_next;

    function automatic logic [63:0] flatten(input row_t r);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < N; i++) begin
            f[i*DATA_WIDTH_output +: DATA_WIDTH_output] = r[i];
        end
        return f;
    endfunction

    function automatic row_t mk(input int a, input int b, input int c, input int d);
        row_t r;
        r[0] = DATA_WIDTH_output'(a);
        r[1] = DATA_WIDTH_output'(b);
        r[2] = DATA_WIDTH_output'(c);
        r[3] = DATA_WIDTH_output'(d);
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < N; i++) begin
            r[i] = DATA_WIDTH_output'($urandom);
        end
        return r;
    endfunction

    function automatic row_t stored_value(input row_t r);
        row_t s;
        s = r;
`ifdef GEMM_COLLECT_RELU_EN
        for (int i = 0; i < N; i++) begin
            if (s[i] < 0) s[i] = '0;
        end
`endif
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every DATA_WIDTH_A-th gen_done after the first row completes one row.
    always @(posedge clk) begin
        if (rst) begin
            gcount     = 0;
            tiles_full = 0;
            exp_ovf    = 1'b0;
            drain_flag = 1'b0;
            exp_data_q.delete();
            exp_last_q.delete();
        end else begin
            t_next = tiles_full;
            if (gen_done) begin
                if (gcount >= DATA_WIDTH_A && (gcount % DATA_WIDTH_A) == 0) begin
                    row_idx = ((gcount / DATA_WIDTH_A) - 1) % M;
                    if (tiles_full == 2) begin
                        exp_ovf = 1'b1;
                    end else begin
                        partial_rows[row_idx] = flatten(stored_value(final_out));
                        if (row_idx == M - 1) begin
                            for (int r = 0; r < M; r++) begin
                                exp_data_q.push_back(partial_rows[r]);
                                exp_last_q.push_back(r == M - 1);
                            end
                            t_next++;
                        end
                    end
                end
                gcount++;
            end
            if (drain_flag) t_next--;
            drain_flag = 1'b0;
            tiles_full = t_next;
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (active) begin
            chk("out_valid", 64'(out_valid), 64'(tiles_full > 0));
            chk("stall", 64'(stall), 64'(tiles_full == 2));
            chk("overflow_err", 64'(overflow_err), 64'(exp_ovf));
            if (tiles_full > 0) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=%0d expected=>0", exp_data_q.size());
                end else begin
                    chk("out_data", flatten(out_data), exp_data_q[0]);
                    chk("out_last", 64'(out_last), 64'(exp_last_q[0]));
                    if (out_ready && !rst) begin
                        if (exp_last_q[0]) drain_flag = 1'b1;
                        void'(exp_data_q.pop_front());
                        void'(exp_last_q.pop_front());
                    end
                end
            end else begin
                chk("out_data_idle", flatten(out_data), 64'd0);
                chk("out_last_idle", 64'(out_last), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        gen_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain_out(input int cycles);
        gen_done  = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) tick();
    endtask

    initial begin
        final_out = mk(0, 0, 0, 0);
        tick();
        active = 1'b1;
        tick();
        rst = 1'b0;

        // Basic capture and drain
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            gen_done  = 1'b1;
            final_out = (i < 9) ? mk(1, -2, 3, -4) : mk(5, 6, 7, 8);
            tick();
        end
        drain_out(6);

        // Stall with an obedient upstream, then release
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            gen_done  = ~stall;
            final_out = rand_row();
            tick();
        end
        drain_out(8);

        // Overflow: upstream ignores stall
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            gen_done  = 1'b1;
            final_out = rand_row();
            tick();
        end
        drain_out(8);

        // Back-pressure toggling every cycle
        do_reset();
        for (int i = 0; i < 200; i++) begin
            out_ready = ((i % 2) == 1);
            gen_done  = ~stall;
            final_out = rand_row();
            tick();
        end
        drain_out(8);

        // Reset mid-tile, then refill with clamp-sensitive data
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            gen_done  = 1'b1;
            final_out = mk(-1, 0, 127, -128);
            tick();
        end
        rst      = 1'b1;
        gen_done = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            gen_done  = 1'b1;
            final_out = (i < 12) ? mk(-1, 0, 127, -128) : mk(-128, 1, -7, 64);
            tick();
        end
        drain_out(6);

        // Random traffic with an obedient upstream
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 1) == 1);
            gen_done  = ($urandom_range(0, 3) != 0) && !stall;
            final_out = rand_row();
            tick();
        end
        drain_out(10);

        checks++;
        if (exp_data_q.size() != 0) begin
            failures++;
            $display("FAIL rows_outstanding actual=%0d expected=0", exp_data_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
